// File: rtl/lcd_bus_sequencer_pkg.sv
// Shared types and constants for the LCD bus sequencer: FSM states, word bit
// positions, command codes and the queued {rs,data} entry.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        WAIT
    } lcd_state_e;

    localparam int LCD_ON_BIT = 31;
    localparam int LCD_RS_BIT = 10;
    localparam int LCD_EN_BIT = 8;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long busy wait on the panel.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_bus_sequencer_if.sv
// LCD buffer word in, LCD pins and status out. The sequencer takes the slave view,
// the CPU-side driver the master view.
interface lcd_bus_sequencer_if;
    logic [31:0] i_lcd_word;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic        o_busy;
    logic        o_overflow;

    modport master (
        output i_lcd_word,
        input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_overflow
    );

    modport slave (
        input  i_lcd_word,
        output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_overflow
    );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// First-word fall-through FIFO for queued LCD strobes. A push while full is
// accepted only when a pop frees the slot in the same cycle.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/lcd_bus_sequencer.sv
// Turns EN strobes in the LCD buffer word into timed HD44780 write cycles:
// setup, E pulse, hold, then a busy wait sized by the command.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int T_SETUP_CYC = 3,
    parameter int T_EN_CYC    = 25,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2500,
    parameter int T_CLR_CYC   = 82000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    lcd_bus_sequencer_if.slave bus
);
    localparam int T_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_CMD_CYC)),
                                T_CLR_CYC);
    localparam int CW    = $clog2(T_MAX) + 1;
    localparam int FW    = $clog2(FIFO_DEPTH) + 1;

    lcd_state_e    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          en_q;
    logic          strobe;
    logic          pop;
    logic          full;
    logic          empty;
    logic [FW-1:0] count;
    lcd_entry_t    wentry;
    lcd_entry_t    rentry;
    logic          rs;
    logic [7:0]    data;
    logic          lcd_en;
    logic          lcd_on;
    logic          overflow;
    logic          unused_word_bits;

    assign strobe = bus.i_lcd_word[LCD_EN_BIT] && !en_q;
    assign wentry = '{rs: bus.i_lcd_word[LCD_RS_BIT], data: bus.i_lcd_word[7:0]};
    assign unused_word_bits = ^{bus.i_lcd_word[30:11], bus.i_lcd_word[9]};

    lcd_cmd_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(9)
    ) fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .push  (strobe),
        .pop   (pop),
        .wdata (wentry),
        .rdata (rentry),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_d   = CW'(T_SETUP_CYC - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    cnt_d   = CW'(T_EN_CYC - 1);
                    state_d = ENABLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ENABLE: begin
                if (cnt == '0) begin
                    cnt_d   = CW'(T_HOLD_CYC - 1);
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    cnt_d   = is_long_cmd(rs, data) ? CW'(T_CLR_CYC - 1) : CW'(T_CMD_CYC - 1);
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // en_q tracks the word even in reset so a level held across release is not an edge.
    always_ff @(posedge i_clk) begin
        en_q <= bus.i_lcd_word[LCD_EN_BIT];
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rs       <= 1'b0;
            data     <= '0;
            lcd_en   <= 1'b0;
            lcd_on   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            lcd_en <= (state_d == ENABLE);
            lcd_on <= bus.i_lcd_word[LCD_ON_BIT];
            if (pop) begin
                {rs, data} <= rentry;
            end
            if (strobe && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.o_lcd_data = data;
    assign bus.o_lcd_rs   = rs;
    assign bus.o_lcd_rw   = 1'b0;
    assign bus.o_lcd_en   = lcd_en;
    assign bus.o_lcd_on   = lcd_on;
    assign bus.o_busy     = (state != IDLE) || (count != '0);
    assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Randomized bench for lcd_bus_sequencer: a timing-level model predicts every E
// pulse (rs, data, rising edge) into a scoreboard that a pin monitor drains.
module tb_lcd_bus_sequencer;
    localparam int DEPTH = 4;
    localparam int TS    = 3;
    localparam int TE    = 25;
    localparam int TH    = 2;
    localparam int TCMD  = 200;
    localparam int TCLR  = 600;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] word;
    logic        on_bit;

    lcd_bus_sequencer_if bus ();
    assign bus.i_lcd_word = word;

    lcd_bus_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .T_SETUP_CYC (TS),
        .T_EN_CYC    (TE),
        .T_HOLD_CYC  (TH),
        .T_CMD_CYC   (TCMD),
        .T_CLR_CYC   (TCLR)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    int   idle_at = 0;
    int   last_rst = -1;
    int   rises = 0;
    bit   exp_busy = 0;
    bit   exp_ovf = 0;
    bit   exp_on = 0;
    logic prev_en = 1'b0;
    logic [8:0] mq[$];
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, k);
        end
    endtask

    function automatic bit is_long(input logic [8:0] e);
        return !e[8] && (e[7:0] >= 8'd1) && (e[7:0] <= 8'd3);
    endfunction

    // Reference model: one transaction occupies the bus for TS+TE+TH+wait edges
    // after its pop; a pop happens on the first edge after the bus is idle.
    initial begin
        logic [8:0] ent;
        bit m_pop, m_push;
        forever begin
            @(posedge clk);
            k++;
            if (rst) begin
                mq.delete();
                sb.delete();
                idle_at  = k;
                last_rst = k;
                exp_ovf  = 0;
                exp_on   = 0;
                exp_busy = 0;
                prev_en  = word[8];
            end else begin
                m_pop   = (mq.size() > 0) && (k > idle_at);
                m_push  = word[8] && !prev_en;
                prev_en = word[8];
                exp_on  = word[31];
                if (m_pop) begin
                    ent = mq.pop_front();
                    sb.push_back('{rs: ent[8], data: ent[7:0], rise: k + TS});
                    idle_at = k + TS + TE + TH + (is_long(ent) ? TCLR : TCMD);
                end
                if (m_push) begin
                    if (mq.size() < DEPTH) mq.push_back({word[10], word[7:0]});
                    else exp_ovf = 1;
                end
                exp_busy = (mq.size() > 0) || (k < idle_at);
            end
        end
    end

    // Pin monitor: each E rise pops the scoreboard; status pins are compared on change.
    initial begin
        exp_t got;
        int   hi_start = 0;
        logic p_en = 0, p_busy = 0, p_ovf = 0, p_on = 0;
        bit   p_ebusy = 0, p_eovf = 0, p_eon = 0;
        forever begin
            @(negedge clk);
            if (k > 0) begin
                if (bus.o_lcd_en && !p_en) begin
                    rises++;
                    hi_start = k;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL pulse_unexpected actual=rs %0d data %02h expected=no pulse (edge %0d)",
                                 bus.o_lcd_rs, bus.o_lcd_data, k);
                    end else begin
                        got = sb.pop_front();
                        chk("pulse_rs", bus.o_lcd_rs, got.rs);
                        chk("pulse_data", bus.o_lcd_data, got.data);
                        chk("pulse_rise_edge", k, got.rise);
                    end
                end
                if (!bus.o_lcd_en && p_en) begin
                    if (last_rst >= hi_start) chk("en_abort_edge", k, last_rst);
                    else chk("en_width", k - hi_start, TE);
                end
                if (bus.o_busy != p_busy || exp_busy != p_ebusy) chk("busy", bus.o_busy, exp_busy);
                if (bus.o_overflow != p_ovf || exp_ovf != p_eovf) chk("overflow", bus.o_overflow, exp_ovf);
                if (bus.o_lcd_on != p_on || exp_on != p_eon) chk("lcd_on", bus.o_lcd_on, exp_on);
                p_en = bus.o_lcd_en;  p_busy = bus.o_busy;  p_ovf = bus.o_overflow;  p_on = bus.o_lcd_on;
                p_ebusy = exp_busy;   p_eovf = exp_ovf;     p_eon = exp_on;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_word(input logic rs, input logic [7:0] d, input logic en);
        word = {on_bit, 20'h0, rs, 1'($urandom_range(0, 1)), en, d};
    endtask

    task automatic strobe(input logic rs, input logic [7:0] d);
        set_word(rs, d, 1'b0);
        cyc(1);
        set_word(rs, d, 1'b1);
        cyc(1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((exp_busy || bus.o_busy) && n < bound) begin
            cyc(1);
            n++;
        end
        chk("wait_idle_in_bound", int'(n < bound), 1);
        cyc(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        int n, r0;
        logic rs;
        logic [7:0] d;
        rst    = 1'b1;
        on_bit = 1'b0;
        word   = 32'h0000_0100;
        cyc(3);
        rst = 1'b0;
        cyc(3);
        chk("reset_busy", bus.o_busy, 0);
        chk("reset_data", bus.o_lcd_data, 0);
        chk("reset_rs", bus.o_lcd_rs, 0);
        chk("reset_en", bus.o_lcd_en, 0);
        chk("reset_rw", bus.o_lcd_rw, 0);
        chk("reset_on", bus.o_lcd_on, 0);
        chk("reset_ovf", bus.o_overflow, 0);

        strobe(1'b1, 8'h41);
        wait_idle(6000);
        chk("data_kept", bus.o_lcd_data, 8'h41);
        chk("rs_kept", bus.o_lcd_rs, 1);

        // Clear followed by queued entries: their rise edges expose the long wait.
        strobe(1'b0, 8'h01);
        strobe(1'b0, 8'h38);
        strobe(1'b1, 8'h42);
        wait_idle(6000);

        for (int i = 0; i < 6; i++) strobe(1'b1, 8'h60 + 8'(i));
        chk("burst_ovf_set", bus.o_overflow, 1);
        wait_idle(6000);
        chk("burst_ovf_sticky", bus.o_overflow, 1);
        do_reset();
        chk("ovf_cleared_by_reset", bus.o_overflow, 0);

        strobe(1'b1, 8'h30);
        for (int i = 1; i <= 4; i++) strobe(1'b1, 8'h30 + 8'(i));
        set_word(1'b1, 8'h39, 1'b0);
        n = 0;
        while (k != idle_at && n < 2000) begin
            cyc(1);
            n++;
        end
        chk("pop_align_in_bound", int'(n < 2000), 1);
        set_word(1'b1, 8'h39, 1'b1);
        cyc(1);
        chk("push_on_pop_no_ovf", bus.o_overflow, 0);
        strobe(1'b1, 8'h3A);
        chk("still_full_ovf", bus.o_overflow, 1);
        wait_idle(6000);
        do_reset();

        strobe(1'b1, 8'h4F);
        cyc(5);
        for (int i = 0; i < 8; i++) begin
            on_bit   = !on_bit;
            word[31] = on_bit;
            chk("on_before_edge", bus.o_lcd_on, !on_bit);
            cyc(1);
            chk("on_after_edge", bus.o_lcd_on, on_bit);
            cyc($urandom_range(0, 2));
        end
        wait_idle(6000);

        strobe(1'b1, 8'h50);
        strobe(1'b1, 8'h51);
        n = 0;
        while (!bus.o_lcd_en && n < 100) begin
            cyc(1);
            n++;
        end
        chk("enable_reached", bus.o_lcd_en, 1);
        cyc(5);
        rst = 1'b1;
        cyc(1);
        chk("en_drop_on_reset", bus.o_lcd_en, 0);
        chk("busy_drop_on_reset", bus.o_busy, 0);
        rst = 1'b0;
        r0 = rises;
        cyc(400);
        chk("no_pulse_after_reset", rises - r0, 0);

        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = (!rs && $urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            on_bit = 1'($urandom_range(0, 1));
            strobe(rs, d);
            if ($urandom_range(0, 3) == 0) begin
                set_word(rs, d, 1'b1);
                cyc($urandom_range(1, 3));
            end
            cyc($urandom_range(0, 40));
        end
        wait_idle(6000);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
